// File: rtl/bridge_pkg.sv
// Shared constants for the data-side bus bridge: FSM encodings and the default CPU address map.
package bridge_pkg;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam int unsigned MapSlaves = 8;
    localparam int unsigned MapAddrW  = 32;

    // DM spans 0x0000-0x2FFF; one base/mask pair can only cover the enclosing 16 KiB window.
    localparam logic [31:0] DmBase    = 32'h0000_0000;
    localparam logic [31:0] DmMask    = 32'hFFFF_C000;
    localparam logic [31:0] T0Base    = 32'h0000_7F00;
    localparam logic [31:0] T0Mask    = 32'hFFFF_FFF0;
    localparam logic [31:0] UartBase  = 32'h0000_7F30;
    localparam logic [31:0] UartMask  = 32'hFFFF_FFF0;
    localparam logic [31:0] DtBase    = 32'h0000_7F50;
    localparam logic [31:0] DtMask    = 32'hFFFF_FFF0;
    localparam logic [31:0] DipSwBase = 32'h0000_7F60;
    localparam logic [31:0] DipSwMask = 32'hFFFF_FFF8;
    localparam logic [31:0] KeyBase   = 32'h0000_7F68;
    localparam logic [31:0] KeyMask   = 32'hFFFF_FFF8;
    localparam logic [31:0] LedBase   = 32'h0000_7F70;
    localparam logic [31:0] LedMask   = 32'hFFFF_FFF8;
    // Zero mask with a non-zero base never matches: spare slot stays unmapped.
    localparam logic [31:0] NoneBase  = 32'h0000_0001;
    localparam logic [31:0] NoneMask  = 32'h0000_0000;

    localparam logic [MapSlaves*MapAddrW-1:0] DefaultBaseVec = {
        NoneBase, LedBase, KeyBase, DipSwBase, DtBase, UartBase, T0Base, DmBase
    };
    localparam logic [MapSlaves*MapAddrW-1:0] DefaultMaskVec = {
        NoneMask, LedMask, KeyMask, DipSwMask, DtMask, UartMask, T0Mask, DmMask
    };

endpackage

// File: rtl/bridge_addr_decoder.sv
// Combinational address decoder: one-hot window hit, lowest slave index wins on overlap.
module bridge_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_VEC = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK_VEC = '0
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!any_hit &&
                ((addr & MASK_VEC[i*ADDR_W +: ADDR_W]) == BASE_VEC[i*ADDR_W +: ADDR_W])) begin
                hit[i]  = 1'b1;
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_bridge_mslave.sv
// CPU data-bus bridge: routes one access at a time to a windowed slave with req/ack handshake,
// bus timeout and error logging.
module bus_bridge_mslave
    import bridge_pkg::*;
#(
    parameter int unsigned NUM_SLAVES = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE_VEC = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK_VEC = '0,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         m_req,
    input  logic                         m_we,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_byteen,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_we,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_byteen,
    input  logic [NUM_SLAVES-1:0]        s_ack,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic [15:0]                  err_count,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int unsigned BeW     = DATA_W / 8;
    localparam int unsigned CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TmoLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(TmoLast);

    logic [1:0]            state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [BeW-1:0]        byteen_q, byteen_d;
    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  m_err_q, m_err_d;
    logic [DATA_W-1:0]     m_rdata_q, m_rdata_d;
    logic [15:0]           err_count_q, err_count_d;
    logic [ADDR_W-1:0]     err_addr_q, err_addr_d;

    logic [NUM_SLAVES-1:0] hit;
    logic                  any_hit;
    logic                  ack_sel;
    logic                  timeout_hit;
    logic [DATA_W-1:0]     sel_rdata;
    logic                  log_err;
    logic [ADDR_W-1:0]     log_addr;

    bridge_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .BASE_VEC   (BASE_VEC),
        .MASK_VEC   (MASK_VEC)
    ) u_decoder (
        .addr    (m_addr),
        .hit     (hit),
        .any_hit (any_hit)
    );

    always_comb begin
        ack_sel     = |(s_ack & sel_q);
        timeout_hit = (TIMEOUT > 0) && (cnt_q == CntLast);
        sel_rdata   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        byteen_d    = byteen_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        m_err_d     = m_err_q;
        m_rdata_d   = m_rdata_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        log_err     = 1'b0;
        log_addr    = m_addr;

        case (state_q)
            StIdle: begin
                if (m_req) begin
                    if (any_hit) begin
                        we_d     = m_we;
                        addr_d   = m_addr;
                        wdata_d  = m_wdata;
                        byteen_d = m_we ? m_byteen : '0;
                        sel_d    = hit;
                        cnt_d    = '0;
                        state_d  = StWait;
                    end else begin
                        m_err_d   = 1'b1;
                        m_rdata_d = '0;
                        log_err   = 1'b1;
                        state_d   = StResp;
                    end
                end
            end
            StWait: begin
                // An ack arriving on the timeout cycle still completes cleanly.
                if (ack_sel) begin
                    m_rdata_d = we_q ? '0 : sel_rdata;
                    m_err_d   = 1'b0;
                    sel_d     = '0;
                    state_d   = StResp;
                end else if (timeout_hit) begin
                    m_rdata_d = '0;
                    m_err_d   = 1'b1;
                    sel_d     = '0;
                    log_err   = 1'b1;
                    log_addr  = addr_q;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                m_err_d   = 1'b0;
                m_rdata_d = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (log_err) begin
            err_count_d = (err_count_q == 16'hFFFF) ? err_count_q : err_count_q + 16'd1;
            err_addr_d  = log_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            byteen_q    <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            m_err_q     <= 1'b0;
            m_rdata_q   <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            byteen_q    <= byteen_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            m_err_q     <= m_err_d;
            m_rdata_q   <= m_rdata_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign m_ready   = (state_q == StResp);
    assign m_err     = m_err_q;
    assign m_rdata   = m_rdata_q;
    assign s_sel     = sel_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_byteen  = byteen_q;
    assign err_count = err_count_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_bridge_mslave.sv
// Scoreboard bench for bus_bridge_mslave: responses are predicted at request time and checked
// against each m_ready pulse, including its cycle.
module tb_bus_bridge_mslave;
    import bridge_pkg::*;

    localparam int unsigned NS = 8;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    // Slave 1 is a T0-like window that also overlaps DM at 0x100 but not the other peripherals.
    localparam logic [NS*AW-1:0] TbBase = {DefaultBaseVec[255:64], 32'h0000_0100,
                                           DefaultBaseVec[31:0]};
    localparam logic [NS*AW-1:0] TbMask = {DefaultMaskVec[255:64], 32'hFFFF_8130,
                                           DefaultMaskVec[31:0]};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             m_req = 1'b0;
    logic             m_we = 1'b0;
    logic [AW-1:0]    m_addr = '0;
    logic [DW-1:0]    m_wdata = '0;
    logic [DW/8-1:0]  m_byteen = '0;
    logic             m_ready;
    logic             m_err;
    logic [DW-1:0]    m_rdata;
    logic [NS-1:0]    s_sel;
    logic             s_we;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wdata;
    logic [DW/8-1:0]  s_byteen;
    logic [NS-1:0]    s_ack = '0;
    logic [NS*DW-1:0] s_rdata = '0;
    logic [15:0]      err_count;
    logic [AW-1:0]    err_addr;

    bus_bridge_mslave #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .BASE_VEC   (TbBase),
        .MASK_VEC   (TbMask),
        .TIMEOUT    (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (m_req),
        .m_we      (m_we),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_byteen  (m_byteen),
        .m_ready   (m_ready),
        .m_err     (m_err),
        .m_rdata   (m_rdata),
        .s_sel     (s_sel),
        .s_we      (s_we),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_byteen  (s_byteen),
        .s_ack     (s_ack),
        .s_rdata   (s_rdata),
        .err_count (err_count),
        .err_addr  (err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t sb_q[$];
    int  n_total = 0;
    int  n_bad = 0;
    int  cyc = 0;

    // Slave responder state (written only by the responder process).
    int          ack_delay = 0;
    logic [NS-1:0] spur_ack = '0;
    int          wait_n = 0;
    int          last_run = 0;
    int          sel_total = 0;
    logic [NS-1:0] last_sel = '0;
    logic [3:0]  last_byteen = '0;
    logic        last_we = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] slave_data(input int i);
        return (i == 0) ? 32'h1234_5678 : (32'hD00D_0000 + 32'(i));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (s_sel != '0) begin
            s_ack       = (wait_n == ack_delay) ? (s_sel | spur_ack) : spur_ack;
            last_sel    = s_sel;
            last_byteen = s_byteen;
            last_we     = s_we;
            wait_n++;
            last_run    = wait_n;
            sel_total++;
        end else begin
            s_ack  = spur_ack;
            wait_n = 0;
        end
    end

    always @(negedge clk) begin
        if (!reset && m_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_ready", {31'b0, m_ready}, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check_eq("rdata", m_rdata, e.rdata);
                check_eq("err", {31'b0, m_err}, {31'b0, e.err});
                check_eq("ready_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat);
        sb_t e;
        bit seen;
        @(negedge clk);
        m_req    = 1'b1;
        m_we     = we;
        m_addr   = addr;
        m_wdata  = wdata;
        m_byteen = be;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.cyc    = cyc + lat;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (m_ready) seen = 1'b1;
        end
        if (!seen) check_eq("ready_bound", {31'b0, m_ready}, 32'd1);
        m_req = 1'b0;
    endtask

    initial begin
        int snap;
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = slave_data(i);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_eq("rst_ready", {31'b0, m_ready}, 32'd0);
        check_eq("rst_err", {31'b0, m_err}, 32'd0);
        check_eq("rst_sel", {24'b0, s_sel}, 32'd0);
        check_eq("rst_rdata", m_rdata, 32'd0);
        check_eq("rst_byteen", {28'b0, s_byteen}, 32'd0);
        check_eq("rst_errcnt", {16'b0, err_count}, 32'd0);
        check_eq("rst_erraddr", err_addr, 32'd0);

        // Read DM, ack in the first WAIT cycle.
        ack_delay = 0;
        do_req(1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 2);
        check_eq("dm_sel", {24'b0, last_sel}, 32'h01);
        check_eq("dm_byteen", {28'b0, last_byteen}, 32'h0);

        // Write T0, ack in the third WAIT cycle.
        ack_delay = 2;
        do_req(1'b1, 32'h0000_7F04, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0, 4);
        check_eq("t0_sel", {24'b0, last_sel}, 32'h02);
        check_eq("t0_sel_run", 32'(last_run), 32'd3);
        check_eq("t0_byteen", {28'b0, last_byteen}, 32'hF);
        check_eq("t0_we", {31'b0, last_we}, 32'd1);
        check_eq("t0_saddr", s_addr, 32'h0000_7F04);
        check_eq("t0_swdata", s_wdata, 32'hDEAD_BEEF);

        // Unmapped.
        snap = sel_total;
        do_req(1'b0, 32'h0000_5000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        check_eq("unm_nosel", 32'(sel_total - snap), 32'd0);
        check_eq("unm_errcnt", {16'b0, err_count}, 32'd1);
        check_eq("unm_erraddr", err_addr, 32'h0000_5000);

        // Timeout on UART, then ack on the last WAIT cycle.
        ack_delay = 255;
        do_req(1'b0, 32'h0000_7F30, 32'h0, 4'h0, 32'h0, 1'b1, TO + 1);
        check_eq("tmo_errcnt", {16'b0, err_count}, 32'd2);
        check_eq("tmo_erraddr", err_addr, 32'h0000_7F30);
        check_eq("tmo_sel_drop", {24'b0, s_sel}, 32'h0);
        ack_delay = TO - 1;
        do_req(1'b0, 32'h0000_7F34, 32'h0, 4'h0, slave_data(2), 1'b0, TO + 1);
        check_eq("late_ack_errcnt", {16'b0, err_count}, 32'd2);

        // Reset while waiting on a slave that never answers.
        ack_delay = 255;
        @(negedge clk);
        m_req  = 1'b1;
        m_we   = 1'b1;
        m_addr = 32'h0000_7F50;
        m_byteen = 4'h3;
        repeat (2) @(negedge clk);
        check_eq("mid_sel", {24'b0, s_sel}, 32'h08);
        reset = 1'b1;
        m_req = 1'b0;
        @(negedge clk);
        check_eq("mrst_sel", {24'b0, s_sel}, 32'h0);
        check_eq("mrst_ready", {31'b0, m_ready}, 32'd0);
        check_eq("mrst_saddr", s_addr, 32'h0);
        check_eq("mrst_byteen", {28'b0, s_byteen}, 32'h0);
        check_eq("mrst_errcnt", {16'b0, err_count}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        ack_delay = 0;
        do_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 2);

        // Overlap at 0x100: slave 0 wins; slave 1 acks are spurious.
        spur_ack  = 8'h02;
        ack_delay = 1;
        do_req(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 3);
        check_eq("ovl_sel", {24'b0, last_sel}, 32'h01);
        spur_ack  = 8'h00;

        // Saturation of the error counter.
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        repeat (2) @(negedge clk);
        release dut.err_count_q;
        do_req(1'b0, 32'h0000_6000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        check_eq("sat_errcnt1", {16'b0, err_count}, 32'h0000_FFFF);
        do_req(1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'h0, 1'b1, 1);
        check_eq("sat_errcnt2", {16'b0, err_count}, 32'h0000_FFFF);
        check_eq("sat_erraddr", err_addr, 32'h0000_9000);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
